// File: rtl/ama_riscv_fetch_pkg.sv
// Shared definitions for the fetch stage: state encodings, NOP constant,
// instruction memory address width and the default boot address.
package ama_riscv_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam int unsigned IMEM_AW      = 14;
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ama_riscv_fetch.sv
// Instruction fetch stage: issues word addresses to a synchronous-read IMEM,
// presents instructions to decode with a valid/ready handshake and handles redirects.
module ama_riscv_fetch
    import ama_riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addrb,
    input  logic [31:0]        imem_doutb,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    input  logic               halt_i,
    output logic [31:0]        inst_o,
    output logic [31:0]        pc_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               misalign_o,
    output logic [31:0]        fetch_cnt_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, nxt_pc;
    logic         vld_q, vld_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         accept;

    // A redirect in the same cycle kills the instruction currently on the output.
    assign valid_o     = vld_q & (state_q == ST_RUN) & ~redirect_i;
    assign accept      = valid_o & ready_i;
    assign inst_o      = valid_o ? imem_doutb : NOP;
    assign pc_o        = pc_q;
    assign misalign_o  = (state_q == ST_FAULT);
    assign fetch_cnt_o = cnt_q;
    assign imem_addrb  = nxt_pc[IMEM_AW+1:2];

    always_comb begin
        state_d = state_q;
        nxt_pc  = pc_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                vld_d   = 1'b1;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    if (is_word_aligned(redirect_pc_i)) begin
                        nxt_pc = redirect_pc_i;
                        vld_d  = 1'b1;
                    end else begin
                        state_d = ST_FAULT;
                        vld_d   = 1'b0;
                    end
                end else if (halt_i) begin
                    state_d = ST_HALT;
                    vld_d   = 1'b0;
                end else if (accept) begin
                    nxt_pc = pc_q + 32'd4;
                end
            end
            ST_HALT, ST_FAULT: begin
                if (redirect_i) begin
                    if (is_word_aligned(redirect_pc_i)) begin
                        state_d = ST_RUN;
                        nxt_pc  = redirect_pc_i;
                        vld_d   = 1'b1;
                    end else begin
                        state_d = ST_FAULT;
                        vld_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_BOOT;
                vld_d   = 1'b0;
            end
        endcase

        if (accept) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= nxt_pc;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Self-checking bench for ama_riscv_fetch: directed scenarios plus randomized
// traffic, checked every cycle against a behavioural fetch model.
module tb_ama_riscv_fetch;

    localparam logic [31:0] NOP_I    = 32'h0000_0013;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [13:0] imem_addrb;
    logic [31:0] imem_doutb;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;

    ama_riscv_fetch #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addrb    (imem_addrb),
        .imem_doutb    (imem_doutb),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .misalign_o    (misalign_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:16383];
    always @(posedge clk) imem_doutb <= mem[imem_addrb];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode 0=booting, 1=running, 2=halted, 3=faulted.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    logic        obs_valid, obs_mis;
    logic [31:0] obs_inst, obs_pc, obs_cnt;
    logic [13:0] obs_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = RST_PC;
        m_cnt  = 32'd0;
    endtask

    // One clock cycle: drive inputs, compare every output against the model
    // on the falling edge, then advance the model across the rising edge.
    task automatic step(input logic rdy, input logic red, input logic [31:0] rpc, input logic hlt);
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] n_pc;
        int          n_mode;
        logic [31:0] n_cnt;
        ready_i       = rdy;
        redirect_i    = red;
        redirect_pc_i = rpc;
        halt_i        = hlt;
        @(negedge clk);

        e_valid = (m_mode == 1) && !red;
        e_inst  = e_valid ? mem[m_pc[15:2]] : NOP_I;
        n_pc    = m_pc;
        n_mode  = m_mode;
        n_cnt   = (e_valid && rdy) ? m_cnt + 32'd1 : m_cnt;
        if (m_mode == 0) begin
            n_mode = 1;
        end else if (red) begin
            if (rpc % 4 == 0) begin
                n_pc   = rpc;
                n_mode = 1;
            end else begin
                n_mode = 3;
            end
        end else if (m_mode == 1 && hlt) begin
            n_mode = 2;
        end else if (m_mode == 1 && rdy) begin
            n_pc = m_pc + 32'd4;
        end

        chk("valid_o", {31'd0, valid_o}, {31'd0, e_valid});
        chk("inst_o", inst_o, e_inst);
        chk("pc_o", pc_o, m_pc);
        chk("misalign_o", {31'd0, misalign_o}, {31'd0, (m_mode == 3)});
        chk("imem_addrb", {18'd0, imem_addrb}, {18'd0, n_pc[15:2]});
        chk("fetch_cnt_o", fetch_cnt_o, m_cnt);

        obs_valid = valid_o;
        obs_mis   = misalign_o;
        obs_inst  = inst_o;
        obs_pc    = pc_o;
        obs_addr  = imem_addrb;
        obs_cnt   = fetch_cnt_o;

        m_pc   = n_pc;
        m_mode = n_mode;
        m_cnt  = n_cnt;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] cnt_before;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0]  = 32'hAAAA_0001;
        mem[1]  = 32'hBBBB_0002;
        mem[64] = 32'hC0DE_0100;

        rst_n = 1'b0; ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'd0; halt_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst misalign_o", {31'd0, misalign_o}, 32'd0);
        chk("rst inst_o", inst_o, NOP_I);
        chk("rst pc_o", pc_o, RST_PC);
        chk("rst imem_addrb", {18'd0, imem_addrb}, 32'd0);
        chk("rst fetch_cnt_o", fetch_cnt_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Boot
        step(1, 0, 0, 0);
        chk("boot valid", {31'd0, obs_valid}, 32'd0);
        step(1, 0, 0, 0);
        chk("boot inst A", obs_inst, 32'hAAAA_0001);
        chk("boot pc 0", obs_pc, 32'd0);
        step(1, 0, 0, 0);
        chk("boot inst B", obs_inst, 32'hBBBB_0002);
        chk("boot pc 4", obs_pc, 32'd4);
        chk("boot cnt 2", fetch_cnt_o, 32'd2);

        // Backpressure at pc 8
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("bp pc", obs_pc, 32'd8);
            chk("bp inst", obs_inst, mem[2]);
            chk("bp addr", {18'd0, obs_addr}, 32'd2);
            chk("bp cnt", obs_cnt, 32'd2);
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("bp release pc", obs_pc, 32'd12);

        // Redirect while valid
        cnt_before = fetch_cnt_o;
        step(1, 1, 32'h100, 0);
        chk("redir drop valid", {31'd0, obs_valid}, 32'd0);
        chk("redir not counted", fetch_cnt_o, cnt_before);
        step(1, 0, 0, 0);
        chk("redir pc", obs_pc, 32'h100);
        chk("redir inst", obs_inst, 32'hC0DE_0100);

        // Misaligned redirect then recovery
        step(1, 1, 32'h102, 0);
        step(1, 0, 0, 0);
        chk("fault mis", {31'd0, obs_mis}, 32'd1);
        chk("fault valid", {31'd0, obs_valid}, 32'd0);
        step(1, 1, 32'h200, 0);
        step(1, 0, 0, 0);
        chk("recover mis", {31'd0, obs_mis}, 32'd0);
        chk("recover pc", obs_pc, 32'h200);

        // Halt + redirect priority, halt alone, wrap-around
        step(1, 1, 32'h40, 1);
        step(1, 0, 0, 0);
        chk("prio pc", obs_pc, 32'h40);
        chk("prio valid", {31'd0, obs_valid}, 32'd1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("halt valid", {31'd0, obs_valid}, 32'd0);
        step(1, 0, 0, 1);
        chk("halt held", {31'd0, obs_valid}, 32'd0);
        step(1, 1, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, 0);
        chk("wrap pc top", obs_pc, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        chk("wrap pc zero", obs_pc, 32'd0);

        // Asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("async valid_o", {31'd0, valid_o}, 32'd0);
        chk("async imem_addrb", {18'd0, imem_addrb}, {18'd0, RST_PC[15:2]});
        chk("async fetch_cnt_o", fetch_cnt_o, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r_red, r_hlt, r_rdy;
            logic [31:0] r_pc;
            r_red = ($urandom_range(0, 11) == 0);
            r_hlt = ($urandom_range(0, 19) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       r_pc = $urandom;
                1:       r_pc = 32'hFFFF_FFF8;
                default: r_pc = {$urandom_range(0, 32'hFFFF), 14'd0, 2'b00} | ($urandom_range(0, 16383) << 2);
            endcase
            step(r_rdy, r_red, r_pc, r_hlt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
